alu_arbiter: RTL and testbench

//  Shares the single 64-bit ALU between N_REQ requesters (e.g. execute stage, address-gen, debug port).

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_arbiter_if.sv | 27 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state and flag types for the ALU arbiter.
// Opcode encodings must match the external 64-bit ALU's cntrl decoding.
package alu_pkg;

  localparam logic [2:0] ALU_PASS_B   = 3'b000;
  localparam logic [2:0] ALU_ADD      = 3'b010;
  localparam logic [2:0] ALU_SUBTRACT = 3'b011;
  localparam logic [2:0] ALU_AND      = 3'b100;
  localparam logic [2:0] ALU_OR       = 3'b101;
  localparam logic [2:0] ALU_XOR      = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } nzvc_t;

  // Only add/subtract produce meaningful V and C; everything else leaves them alone.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUBTRACT);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side handshake bundle: request channel in, response channel out.
// Slice i of every vector belongs to requester i.
interface alu_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 64
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_A;
  logic [N_REQ*WIDTH-1:0] req_B;
  logic [N_REQ*3-1:0]     req_cntrl;
  logic [N_REQ-1:0]       req_setflags;
  logic [N_REQ-1:0]       resp_valid;
  logic [N_REQ-1:0]       resp_ready;
  logic [WIDTH-1:0]       resp_out;
  logic [3:0]             resp_nzvc;

  modport master (
    output req_valid, req_A, req_B, req_cntrl, req_setflags, resp_ready,
    input  req_ready, resp_valid, resp_out, resp_nzvc
  );

  modport slave (
    input  req_valid, req_A, req_B, req_cntrl, req_setflags, resp_ready,
    output req_ready, resp_valid, resp_out, resp_nzvc
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping from N_REQ-1 back to 0. Grant is all-zero when nothing is requested.
module rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDW-1:0]   grant_id_o
);

  int   idx;
  logic found;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    found      = 1'b0;
    idx        = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = (int'(ptr_i) + off) % N_REQ;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_id_o   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU among N_REQ requesters, one op in flight at a time,
// and owns the architectural NZVC flag register.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  alu_arbiter_if.slave     bus,
  output logic [3:0]       flags_nzvc,
  output logic             busy,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [2:0]       alu_cntrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   rr_ptr_d;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   grant_id;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] resp_valid_q;
  logic             setflags_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [WIDTH-1:0] resp_out_q;
  logic [2:0]       alu_cntrl_q;
  nzvc_t            alu_flags;
  nzvc_t            resp_nzvc_q;
  nzvc_t            flags_q;
  nzvc_t            flags_d;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req_i      (bus.req_valid),
    .ptr_i      (rr_ptr_q),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  // Grant is only offered while idle; a transfer is any asserted ready bit.
  assign bus.req_ready = (state_q == IDLE && !reset) ? grant : '0;

  assign rr_ptr_d  = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + IDW'(1);
  assign alu_flags = '{n: alu_negative, z: alu_zero, v: alu_overflow, c: alu_carry};

  // Logical and unlisted opcodes refresh N,Z only; V,C carry over.
  always_comb begin
    flags_d = alu_flags;
    if (!is_arith(alu_cntrl_q)) begin
      flags_d.v = flags_q.v;
      flags_d.c = flags_q.c;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      setflags_q   <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cntrl_q  <= ALU_PASS_B;
      resp_valid_q <= '0;
      resp_out_q   <= '0;
      resp_nzvc_q  <= '0;
      flags_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.req_ready) begin
            alu_a_q     <= bus.req_A[int'(grant_id)*WIDTH +: WIDTH];
            alu_b_q     <= bus.req_B[int'(grant_id)*WIDTH +: WIDTH];
            alu_cntrl_q <= bus.req_cntrl[int'(grant_id)*3 +: 3];
            setflags_q  <= bus.req_setflags[grant_id];
            id_q        <= grant_id;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          resp_out_q         <= alu_out;
          resp_nzvc_q        <= alu_flags;
          resp_valid_q       <= '0;
          resp_valid_q[id_q] <= 1'b1;
          if (setflags_q) begin
            flags_q <= flags_d;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (bus.resp_ready[id_q]) begin
            resp_valid_q <= '0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_out   = resp_out_q;
  assign bus.resp_nzvc  = resp_nzvc_q;
  assign flags_nzvc     = flags_q;
  assign busy           = (state_q != IDLE);
  assign alu_A          = alu_a_q;
  assign alu_B          = alu_b_q;
  assign alu_cntrl      = alu_cntrl_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with N_REQ=2 and a behavioural 64-bit ALU;
// inputs change and outputs are sampled on the falling edge.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N_REQ = 2;
  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       flags_nzvc;
  logic             busy;
  logic [WIDTH-1:0] alu_A, alu_B, alu_out;
  logic [2:0]       alu_cntrl;
  logic             alu_n, alu_z, alu_v, alu_c;
  logic [WIDTH:0]   sum;

  int n_vec = 0;
  int n_err = 0;

  alu_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  alu_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .flags_nzvc   (flags_nzvc),
    .busy         (busy),
    .alu_A        (alu_A),
    .alu_B        (alu_B),
    .alu_cntrl    (alu_cntrl),
    .alu_out      (alu_out),
    .alu_negative (alu_n),
    .alu_zero     (alu_z),
    .alu_overflow (alu_v),
    .alu_carry    (alu_c)
  );

  always #5 clk = ~clk;

  // ARM-style ALU: C on subtract means "no borrow".
  always_comb begin
    sum     = '0;
    alu_out = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    case (alu_cntrl)
      ALU_PASS_B: alu_out = alu_B;
      ALU_ADD: begin
        sum     = {1'b0, alu_A} + {1'b0, alu_B};
        alu_out = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (alu_A[63] == alu_B[63]) && (alu_out[63] != alu_A[63]);
      end
      ALU_SUBTRACT: begin
        sum     = {1'b0, alu_A} + {1'b0, ~alu_B} + 65'd1;
        alu_out = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (alu_A[63] != alu_B[63]) && (alu_out[63] != alu_A[63]);
      end
      ALU_AND: alu_out = alu_A & alu_B;
      ALU_OR:  alu_out = alu_A | alu_B;
      ALU_XOR: alu_out = alu_A ^ alu_B;
      default: alu_out = '0;
    endcase
    alu_n = alu_out[63];
    alu_z = (alu_out == '0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] op, input logic s);
    bus.req_A[id*WIDTH +: WIDTH] = a;
    bus.req_B[id*WIDTH +: WIDTH] = b;
    bus.req_cntrl[id*3 +: 3]     = op;
    bus.req_setflags[id]         = s;
    bus.req_valid[id]            = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single-requester op from IDLE through consumption; called and returns at a falling edge.
  task automatic run_op(input string name, input int id, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] op, input logic s, input logic [63:0] exp_out,
                        input logic [3:0] exp_rn, input logic [3:0] fl_before, input logic [3:0] fl_after);
    logic [1:0] gnt;
    gnt = 2'b01 << id;
    set_req(id, a, b, op, s);
    #1;
    check({name, " req_ready"}, 64'(bus.req_ready), 64'(gnt));
    tick();
    bus.req_valid = '0;
    check({name, " exec busy"}, 64'(busy), 64'd1);
    check({name, " exec resp_valid"}, 64'(bus.resp_valid), 64'd0);
    check({name, " alu_A"}, alu_A, a);
    check({name, " alu_B"}, alu_B, b);
    check({name, " alu_cntrl"}, 64'(alu_cntrl), 64'(op));
    check({name, " exec flags"}, 64'(flags_nzvc), 64'(fl_before));
    tick();
    check({name, " resp_valid"}, 64'(bus.resp_valid), 64'(gnt));
    check({name, " resp_out"}, bus.resp_out, exp_out);
    check({name, " resp_nzvc"}, 64'(bus.resp_nzvc), 64'(exp_rn));
    check({name, " flags"}, 64'(flags_nzvc), 64'(fl_after));
    bus.resp_ready = gnt;
    tick();
    bus.resp_ready = '0;
    check({name, " done resp_valid"}, 64'(bus.resp_valid), 64'd0);
    check({name, " done busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    bus.req_valid    = '0;
    bus.req_A        = '0;
    bus.req_B        = '0;
    bus.req_cntrl    = '0;
    bus.req_setflags = '0;
    bus.resp_ready   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy",       64'(busy), 64'd0);
    check("rst req_ready",  64'(bus.req_ready), 64'd0);
    check("rst resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst resp_out",   bus.resp_out, 64'd0);
    check("rst resp_nzvc",  64'(bus.resp_nzvc), 64'd0);
    check("rst flags",      64'(flags_nzvc), 64'd0);
    check("rst alu_A",      alu_A, 64'd0);
    check("rst alu_B",      alu_B, 64'd0);
    check("rst alu_cntrl",  64'(alu_cntrl), 64'd0);
    reset = 1'b0;
    tick();

    // Flag behaviour across arithmetic, logical, unlisted and no-S ops.
    run_op("add1",  0, 64'd1, 64'd1, ALU_ADD, 1'b1, 64'd2, 4'b0000, 4'b0000, 4'b0000);
    run_op("sub12", 1, 64'd1, 64'd2, ALU_SUBTRACT, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 4'b0000, 4'b1000);
    run_op("addov", 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, ALU_ADD, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFE, 4'b1010, 4'b1000, 4'b1010);
    run_op("and0",  1, 64'd0, 64'h1234, ALU_AND, 1'b1, 64'd0, 4'b0100, 4'b1010, 4'b0110);
    run_op("subns", 0, 64'h8000_0000_0000_0000, 64'd2, ALU_SUBTRACT, 1'b0,
           64'h7FFF_FFFF_FFFF_FFFE, 4'b0011, 4'b0110, 4'b0110);
    run_op("passb", 1, 64'd5, 64'h8000_0000_0000_0001, ALU_PASS_B, 1'b1,
           64'h8000_0000_0000_0001, 4'b1000, 4'b0110, 4'b1010);
    run_op("op111", 0, 64'd9, 64'd9, 3'b111, 1'b1, 64'd0, 4'b0100, 4'b1010, 4'b0110);
    run_op("orns",  1, 64'hF0, 64'h0F, ALU_OR, 1'b0, 64'hFF, 4'b0000, 4'b0110, 4'b0110);

    // Contention with rr_ptr=0: r0 first, r1 next, then r0's re-armed op.
    set_req(0, 64'd5, 64'd3, ALU_XOR, 1'b0);
    set_req(1, 64'd10, 64'd20, ALU_ADD, 1'b0);
    #1;
    check("tie0 grant", 64'(bus.req_ready), 64'b01);
    tick();
    set_req(0, 64'd100, 64'd1, ALU_SUBTRACT, 1'b0);
    check("tie exec ready", 64'(bus.req_ready), 64'd0);
    tick();
    check("tie r0 resp_valid", 64'(bus.resp_valid), 64'b01);
    check("tie r0 resp_out",   bus.resp_out, 64'd6);
    check("tie resp ready",    64'(bus.req_ready), 64'd0);
    bus.resp_ready = 2'b10;
    tick();
    check("wrong resp_ready held", 64'(bus.resp_valid), 64'b01);
    check("wrong resp_ready busy", 64'(busy), 64'd1);
    bus.resp_ready = 2'b01;
    tick();
    bus.resp_ready = '0;
    check("tie1 grant r1", 64'(bus.req_ready), 64'b10);
    tick();
    bus.req_valid[1] = 1'b0;
    tick();
    check("tie r1 resp_valid", 64'(bus.resp_valid), 64'b10);
    check("tie r1 resp_out",   bus.resp_out, 64'd30);
    bus.resp_ready = 2'b10;
    tick();
    bus.resp_ready = '0;
    check("tie2 grant r0", 64'(bus.req_ready), 64'b01);
    tick();
    bus.req_valid[0] = 1'b0;
    tick();
    check("r0 again resp_valid", 64'(bus.resp_valid), 64'b01);
    check("r0 again resp_out",   bus.resp_out, 64'd99);
    check("r0 again resp_nzvc",  64'(bus.resp_nzvc), 64'b0001);
    bus.resp_ready = 2'b01;
    tick();
    bus.resp_ready = '0;

    // Backpressure: r1 result held for 5 cycles while r0 waits.
    set_req(1, 64'd3, 64'd4, ALU_ADD, 1'b0);
    #1;
    check("bp grant", 64'(bus.req_ready), 64'b10);
    tick();
    bus.req_valid[1] = 1'b0;
    set_req(0, 64'd1, 64'd1, ALU_OR, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp resp_valid", 64'(bus.resp_valid), 64'b10);
      check("bp resp_out",   bus.resp_out, 64'd7);
      check("bp req_ready",  64'(bus.req_ready), 64'd0);
      check("bp busy",       64'(busy), 64'd1);
      tick();
    end
    bus.resp_ready = 2'b10;
    tick();
    bus.resp_ready = '0;
    check("bp released resp_valid", 64'(bus.resp_valid), 64'd0);
    check("bp released grant",      64'(bus.req_ready), 64'b01);
    bus.req_valid = '0;
    tick();

    // Reset while in EXEC discards the op and its flag update; pointer returns to 0.
    set_req(0, 64'd1, 64'd2, ALU_SUBTRACT, 1'b1);
    tick();
    bus.req_valid = '0;
    check("rexec busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    check("rexec busy0",      64'(busy), 64'd0);
    check("rexec resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rexec resp_out",   bus.resp_out, 64'd0);
    check("rexec resp_nzvc",  64'(bus.resp_nzvc), 64'd0);
    check("rexec flags",      64'(flags_nzvc), 64'd0);
    check("rexec alu_A",      alu_A, 64'd0);
    check("rexec alu_B",      alu_B, 64'd0);
    check("rexec alu_cntrl",  64'(alu_cntrl), 64'd0);
    reset = 1'b0;
    tick();
    tick();
    check("rexec no resp",  64'(bus.resp_valid), 64'd0);
    check("rexec no flags", 64'(flags_nzvc), 64'd0);
    set_req(0, 64'd0, 64'd0, ALU_PASS_B, 1'b0);
    set_req(1, 64'd0, 64'd0, ALU_PASS_B, 1'b0);
    #1;
    check("rexec ptr reset grant", 64'(bus.req_ready), 64'b01);
    bus.req_valid = '0;
    tick();
    run_op("post", 1, 64'd1, 64'd1, ALU_ADD, 1'b1, 64'd2, 4'b0000, 4'b0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
